// File: rtl/muller_pkg.sv
// Shared defaults for the muller_c C-element bank, plus the per-lane
// C-element next-state function used by the top.
package muller_pkg;

  localparam int unsigned MULLER_WIDTH_DFLT = 1;
  localparam logic        MULLER_RVAL_DFLT  = 1'b1;

  // Output follows the inputs when they agree and holds when they differ.
  function automatic logic c_next(input logic a, input logic b, input logic o);
    return (a & b) | (o & (a | b));
  endfunction

endpackage

// File: rtl/muller_c_if.sv
// Lane-vector bundle between the C-element bank and its handshake neighbours.
interface muller_c_if
  import muller_pkg::*;
#(
  parameter int unsigned WIDTH = MULLER_WIDTH_DFLT
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] o;
  logic [WIDTH-1:0] ev;

  modport master (output a, output b, input o, input ev);
  modport slave  (input a, input b, output o, output ev);

endinterface

// File: rtl/muller_sync2.sv
// WIDTH-bit two-flop synchroniser; flops reset asynchronously to RVAL so that
// reset release cannot create a spurious transition downstream.
module muller_sync2
  import muller_pkg::*;
#(
  parameter int unsigned WIDTH = MULLER_WIDTH_DFLT,
  parameter logic        RVAL  = MULLER_RVAL_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= {WIDTH{RVAL}};
      sync <= {WIDTH{RVAL}};
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/muller_c.sv
// Bank of WIDTH clocked Muller C-elements with per-lane transition strobe.
// Define MULLER_C_SYNC_EN to pass a and b through two-flop synchronisers.
module muller_c
  import muller_pkg::*;
#(
  parameter int unsigned WIDTH = MULLER_WIDTH_DFLT,
  parameter logic        RVAL  = MULLER_RVAL_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  muller_c_if.slave  bus
);

  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_n;
  logic [WIDTH-1:0] ev_q;

`ifdef MULLER_C_SYNC_EN
  muller_sync2 #(.WIDTH(WIDTH), .RVAL(RVAL)) u_sync_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.a),
    .q     (a_s)
  );

  muller_sync2 #(.WIDTH(WIDTH), .RVAL(RVAL)) u_sync_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.b),
    .q     (b_s)
  );
`else
  assign a_s = bus.a;
  assign b_s = bus.b;
`endif

  always_comb begin
    o_n = o_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_n[i] = c_next(a_s[i], b_s[i], o_q[i]);
    end
  end

  // ev marks the cycle after any lane's state toggled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q  <= {WIDTH{RVAL}};
      ev_q <= '0;
    end else begin
      o_q  <= o_n;
      ev_q <= o_n ^ o_q;
    end
  end

  assign bus.o  = o_q;
  assign bus.ev = ev_q;

endmodule

// File: tb/tb_muller_c.sv
// Scoreboard bench for muller_c: two 4-lane instances (RVAL=1 and RVAL=0)
// share stimulus; a monitor checks o/ev after every rising edge.
module tb_muller_c;

`ifdef MULLER_C_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic clk;
  logic clk_en;
  logic rst_n;

  muller_c_if #(.WIDTH(4)) if1 ();
  muller_c_if #(.WIDTH(4)) if0 ();

  muller_c #(.WIDTH(4), .RVAL(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  muller_c #(.WIDTH(4), .RVAL(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = clk_en ? ~clk : 1'b0;
  end

  typedef struct packed {
    logic [3:0] o1;
    logic [3:0] ev1;
    logic [3:0] o0;
    logic [3:0] ev0;
  } exp_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       r;
    logic [3:0] o1;
    logic [3:0] ev1;
    logic [3:0] o0;
    logic [3:0] ev0;
  } vec_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model state; index 0 models RVAL=1, index 1 models RVAL=0.
  logic [3:0] m_o[2];
  logic [3:0] m_sa1[2], m_sa2[2], m_sb1[2], m_sb2[2];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] av, input logic [3:0] bv, input logic r,
                            output exp_t e);
    logic [3:0] ae, be, on, evv[2];
    logic [3:0] rv;
    for (int k = 0; k < 2; k++) begin
      rv = (k == 0) ? 4'b1111 : 4'b0000;
      if (!r) begin
        m_o[k] = rv; m_sa1[k] = rv; m_sa2[k] = rv; m_sb1[k] = rv; m_sb2[k] = rv;
        evv[k] = 4'b0000;
      end else begin
        ae = SYNC ? m_sa2[k] : av;
        be = SYNC ? m_sb2[k] : bv;
        on = (ae & be) | (m_o[k] & (ae | be));
        evv[k] = on ^ m_o[k];
        m_o[k] = on;
        m_sa2[k] = m_sa1[k]; m_sa1[k] = av;
        m_sb2[k] = m_sb1[k]; m_sb1[k] = bv;
      end
    end
    e.o1 = m_o[0]; e.ev1 = evv[0];
    e.o0 = m_o[1]; e.ev0 = evv[1];
  endtask

  task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic r,
                      input bit use_hand, input exp_t hand);
    exp_t e;
    bit   fell;
    @(negedge clk);
    fell = rst_n && !r;
    if1.a = av; if1.b = bv;
    if0.a = av; if0.b = bv;
    rst_n = r;
    model_step(av, bv, r, e);
    q.push_back(use_hand ? hand : e);
    if (fell) begin
      #1;
      chk("async_rst_o1", if1.o, 4'b1111);
      chk("async_rst_ev1", if1.ev, 4'b0000);
      chk("async_rst_o0", if0.o, 4'b0000);
      chk("async_rst_ev0", if0.ev, 4'b0000);
    end
  endtask

  // Monitor: every rising edge has exactly one expectation queued by stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("o_rval1", if1.o, e.o1);
        chk("ev_rval1", if1.ev, e.ev1);
        chk("o_rval0", if0.o, e.o0);
        chk("ev_rval0", if0.ev, e.ev0);
      end
    end
  end

  vec_t dir[16];
  exp_t dummy;

  initial begin
    dir = '{
      '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000},
      '{4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b1111},
      '{4'b1010, 4'b0101, 1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b0000},
      '{4'b1010, 4'b0101, 1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b0000},
      '{4'b0101, 4'b1010, 1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b0000},
      '{4'b0101, 4'b1010, 1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b0000},
      '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b1111},
      '{4'b1010, 4'b0101, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
      '{4'b0101, 4'b1010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
      '{4'b1100, 4'b1010, 1'b1, 4'b1000, 4'b1000, 4'b1000, 4'b1000},
      '{4'b0110, 4'b0011, 1'b1, 4'b0010, 4'b1010, 4'b0010, 4'b1010},
      '{4'b0110, 4'b0011, 1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0000},
      '{4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000},
      '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000},
      '{4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b1111},
      '{4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b0000}
    };

    clk_en = 1'b0;
    rst_n  = 1'b1;
    if1.a = '0; if1.b = '0;
    if0.a = '0; if0.b = '0;

    // Reset with the clock stopped: outputs must respond immediately.
    #5 rst_n = 1'b0;
    model_step(4'b0000, 4'b0000, 1'b0, dummy);
    #1;
    chk("rst_noclk_o1", if1.o, 4'b1111);
    chk("rst_noclk_ev1", if1.ev, 4'b0000);
    chk("rst_noclk_o0", if0.o, 4'b0000);
    chk("rst_noclk_ev0", if0.ev, 4'b0000);

    clk_en = 1'b1;
    foreach (dir[i]) begin
      step(dir[i].a, dir[i].b, dir[i].r, !SYNC,
           '{dir[i].o1, dir[i].ev1, dir[i].o0, dir[i].ev0});
    end

    for (int i = 0; i < 10000; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 63) != 0), 1'b0, '0);
    end

    repeat (4) @(posedge clk);
    #2;
    n_vec++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
